// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core LSU (M0) and a secondary bus master (M1).
// Round-robin arbitration, one transaction in flight, one-entry posted store buffer for M0.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_read_en,
    input  logic          m0_write_en,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_read_vd,
    output logic          m0_stall,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rvalid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          last_reg, last_next;
    logic          mem_req_reg, mem_req_next;
    logic          mem_we_reg, mem_we_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic          wbuf_v_reg, wbuf_v_next;
    logic [AW-1:0] wbuf_addr_reg, wbuf_addr_next;
    logic [DW-1:0] wbuf_data_reg, wbuf_data_next;

    logic in_xfer;
    logic ack_live;
    logic m0_pend;
    logic m1_pend;
    logic grant_m0;
    logic grant_m1;
    logic wbuf_done;
    logic rd_return;

    assign in_xfer   = (state_reg != IDLE);
    assign ack_live  = mem_ack && (state_reg == REQ);
    // A buffered store masks the load so the read can never overtake it.
    assign m0_pend   = wbuf_v_reg || m0_read_en;
    assign m1_pend   = m1_req && !(in_xfer && (owner_reg == OWN_M1));
    // last_reg holds the previous winner; a tie goes to the other master.
    assign grant_m0  = m0_pend && (!m1_pend || (last_reg == OWN_M1));
    assign grant_m1  = m1_pend && (!m0_pend || (last_reg == OWN_M0));
    assign wbuf_done = ack_live && (owner_reg == OWN_M0) && mem_we_reg;
    assign rd_return = !rst && mem_rvalid && in_xfer && !mem_we_reg;

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (grant_m0) begin
                    state_next     = REQ;
                    owner_next     = OWN_M0;
                    last_next      = OWN_M0;
                    mem_req_next   = 1'b1;
                    mem_we_next    = wbuf_v_reg;
                    mem_addr_next  = wbuf_v_reg ? wbuf_addr_reg : m0_addr;
                    mem_wdata_next = wbuf_v_reg ? wbuf_data_reg : '0;
                end else if (grant_m1) begin
                    state_next     = REQ;
                    owner_next     = OWN_M1;
                    last_next      = OWN_M1;
                    mem_req_next   = 1'b1;
                    mem_we_next    = m1_we;
                    mem_addr_next  = m1_addr;
                    mem_wdata_next = m1_wdata;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    mem_req_next = 1'b0;
                    if (mem_we_reg || mem_rvalid) begin
                        state_next = IDLE;
                    end else begin
                        state_next = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        wbuf_v_next    = wbuf_v_reg;
        wbuf_addr_next = wbuf_addr_reg;
        wbuf_data_next = wbuf_data_reg;
        if (m0_write_en && !wbuf_v_reg) begin
            wbuf_v_next    = 1'b1;
            wbuf_addr_next = m0_addr;
            wbuf_data_next = m0_wdata;
        end else if (wbuf_done) begin
            wbuf_v_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_M0;
            last_reg      <= OWN_M1;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            wbuf_v_reg    <= 1'b0;
            wbuf_addr_reg <= '0;
            wbuf_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            wbuf_v_reg    <= wbuf_v_next;
            wbuf_addr_reg <= wbuf_addr_next;
            wbuf_data_reg <= wbuf_data_next;
        end
    end

    // Return paths are combinational so the requester releases on the data cycle.
    assign m0_read_vd = rd_return && (owner_reg == OWN_M0);
    assign m1_rvalid  = rd_return && (owner_reg == OWN_M1);
    assign m0_rdata   = mem_rdata;
    assign m1_rdata   = mem_rdata;
    assign m1_gnt     = !rst && ack_live && (owner_reg == OWN_M1);
    assign m0_stall   = !rst && m0_write_en && wbuf_v_reg;

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs driven at the falling edge, outputs checked 1ns later.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_read_en;
    logic        m0_write_en;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m0_rdata;
    logic        m0_read_vd;
    logic        m0_stall;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic [31:0] m1_rdata;
    logic        m1_rvalid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_read_en (m0_read_en),
        .m0_write_en(m0_write_en),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m0_read_vd (m0_read_vd),
        .m0_stall   (m0_stall),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_gnt     (m1_gnt),
        .m1_rdata   (m1_rdata),
        .m1_rvalid  (m1_rvalid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; m0_read_en = 1'b1; m0_write_en = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF; mem_rvalid = 1'b1;

        // Reset held with mem_rvalid and a load request active
        nxt(); nxt(); #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_read_vd", m0_read_vd, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_stall", m0_stall, 0);
        $display("txn reset done");

        // M0 load 0x100: ack two cycles later, data two cycles after ack
        nxt(); rst = 1'b0; mem_rvalid = 1'b0; m0_read_en = 1'b1; m0_addr = 32'h100; #1;
        check("ld_req_not_yet", mem_req, 0);
        nxt(); #1;
        check("ld_req", mem_req, 1);
        check("ld_addr", mem_addr, 32'h100);
        check("ld_we", mem_we, 0);
        nxt(); mem_ack = 1'b1; #1;
        check("ld_vd_at_ack", m0_read_vd, 0);
        nxt(); mem_ack = 1'b0; #1;
        check("ld_req_drop", mem_req, 0);
        check("ld_vd_wait", m0_read_vd, 0);
        nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
        check("ld_vd", m0_read_vd, 1);
        check("ld_data", m0_rdata, 32'hDEADBEEF);
        check("ld_m1_rvalid", m1_rvalid, 0);
        nxt(); mem_rvalid = 1'b0; m0_read_en = 1'b0; #1;
        check("ld_vd_pulse", m0_read_vd, 0);
        nxt(); #1;
        check("ld_idle", mem_req, 0);
        $display("txn m0 load 0x100");

        // Two stores, second stalls until the first is acked
        m0_write_en = 1'b1; m0_addr = 32'h200; m0_wdata = 32'h55; #1;
        check("st_stall0", m0_stall, 0);
        nxt(); m0_addr = 32'h204; m0_wdata = 32'h66; #1;
        check("st_stall1", m0_stall, 1);
        nxt(); #1;
        check("st1_req", mem_req, 1);
        check("st1_addr", mem_addr, 32'h200);
        check("st1_wdata", mem_wdata, 32'h55);
        check("st1_we", mem_we, 1);
        check("st_stall2", m0_stall, 1);
        nxt(); #1;
        check("st_stall3", m0_stall, 1);
        nxt(); mem_ack = 1'b1; #1;
        check("st_stall_ack", m0_stall, 1);
        nxt(); mem_ack = 1'b0; #1;
        check("st_stall_free", m0_stall, 0);
        check("st_gap", mem_req, 0);
        nxt(); m0_write_en = 1'b0; #1;
        check("st2_not_yet", mem_req, 0);
        nxt(); #1;
        check("st2_req", mem_req, 1);
        check("st2_addr", mem_addr, 32'h204);
        check("st2_wdata", mem_wdata, 32'h66);
        check("st2_we", mem_we, 1);
        mem_ack = 1'b1;
        nxt(); mem_ack = 1'b0; #1;
        check("st2_done", mem_req, 0);
        $display("txn m0 stores 0x200,0x204");

        // Store then load to the same address: write must reach memory first
        m0_write_en = 1'b1; m0_addr = 32'h300; m0_wdata = 32'hA5;
        nxt(); m0_write_en = 1'b0; m0_read_en = 1'b1; m0_addr = 32'h300;
        nxt(); #1;
        check("raw_first_we", mem_we, 1);
        check("raw_first_addr", mem_addr, 32'h300);
        check("raw_first_wdata", mem_wdata, 32'hA5);
        mem_ack = 1'b1; #1;
        check("raw_no_vd_on_wr", m0_read_vd, 0);
        nxt(); mem_ack = 1'b0; #1;
        check("raw_gap", mem_req, 0);
        nxt(); #1;
        check("raw_rd_req", mem_req, 1);
        check("raw_rd_we", mem_we, 0);
        check("raw_rd_addr", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5; #1;
        check("raw_vd", m0_read_vd, 1);
        check("raw_data", m0_rdata, 32'hA5);
        nxt(); mem_ack = 1'b0; mem_rvalid = 1'b0; m0_read_en = 1'b0; #1;
        check("raw_vd_off", m0_read_vd, 0);
        $display("txn m0 store+load 0x300");

        // Reset in the middle of a load with a store buffered, then a late rvalid
        nxt(); m0_read_en = 1'b1; m0_addr = 32'h400;
        nxt(); m0_write_en = 1'b1; m0_addr = 32'h500; m0_wdata = 32'h77; #1;
        check("mid_req", mem_req, 1);
        nxt(); rst = 1'b1; m0_write_en = 1'b0; m0_read_en = 1'b0;
        nxt(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234; #1;
        check("mid_req_drop", mem_req, 0);
        check("mid_late_vd", m0_read_vd, 0);
        check("mid_late_m1", m1_rvalid, 0);
        nxt(); mem_rvalid = 1'b0; #1;
        check("mid_wbuf_gone", mem_req, 0);
        $display("txn reset mid-load");

        // M0 load and M1 read contending: grants go M0, M1, M0, M1
        nxt(); m0_read_en = 1'b1; m0_addr = 32'h600;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h700;
        nxt(); #1;
        check("rr1_addr", mem_addr, 32'h600);
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11; #1;
        check("rr1_vd", m0_read_vd, 1);
        check("rr1_m1_gnt", m1_gnt, 0);
        check("rr1_m1_rvalid", m1_rvalid, 0);
        nxt(); mem_ack = 1'b0; mem_rvalid = 1'b0; #1;
        check("rr_gap1", mem_req, 0);
        nxt(); #1;
        check("rr2_addr", mem_addr, 32'h700);
        check("rr2_gnt_pre", m1_gnt, 0);
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h22; #1;
        check("rr2_gnt", m1_gnt, 1);
        check("rr2_rvalid", m1_rvalid, 1);
        check("rr2_data", m1_rdata, 32'h22);
        check("rr2_m0_vd", m0_read_vd, 0);
        nxt(); mem_ack = 1'b0; mem_rvalid = 1'b0; m1_addr = 32'h704; #1;
        check("rr_gap2", mem_req, 0);
        nxt(); #1;
        check("rr3_addr", mem_addr, 32'h600);
        mem_ack = 1'b1; #1;
        check("rr3_m1_gnt", m1_gnt, 0);
        check("rr3_vd_early", m0_read_vd, 0);
        nxt(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h33; #1;
        check("rr3_vd", m0_read_vd, 1);
        check("rr3_data", m0_rdata, 32'h33);
        nxt(); mem_rvalid = 1'b0; m0_read_en = 1'b0;
        nxt(); #1;
        check("rr4_addr", mem_addr, 32'h704);
        mem_ack = 1'b1; #1;
        check("rr4_gnt", m1_gnt, 1);
        check("rr4_rvalid_early", m1_rvalid, 0);
        nxt(); mem_ack = 1'b0; m1_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h44; #1;
        check("rr4_rvalid", m1_rvalid, 1);
        check("rr4_data", m1_rdata, 32'h44);
        check("rr4_gnt_off", m1_gnt, 0);
        nxt(); #1;
        check("idle_rvalid_m1", m1_rvalid, 0);
        check("idle_rvalid_m0", m0_read_vd, 0);
        check("rr_end_idle", mem_req, 0);
        $display("txn round-robin m0/m1 reads");

        // M1 write
        nxt(); mem_rvalid = 1'b0; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h800; m1_wdata = 32'h99;
        nxt(); #1;
        check("m1w_we", mem_we, 1);
        check("m1w_addr", mem_addr, 32'h800);
        check("m1w_wdata", mem_wdata, 32'h99);
        mem_ack = 1'b1; #1;
        check("m1w_gnt", m1_gnt, 1);
        nxt(); mem_ack = 1'b0; m1_req = 1'b0; #1;
        check("m1w_done", mem_req, 0);
        $display("txn m1 write 0x800");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
